// File: rtl/pipeline_pkg.sv
// Shared encodings and state type for the five-stage RV32 pipeline control logic.
package pipeline_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/forward_unit.sv
// Combinational ALU operand bypass select; the Memory stage result wins over Write-back.
module forward_unit
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] Rs1E,
    input  logic [ADDR_W-1:0] Rs2E,
    input  logic [ADDR_W-1:0] RdM,
    input  logic [ADDR_W-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE
);

    logic [ADDR_W-1:0] rs_e [2];
    logic [1:0]        fwd  [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            always_comb begin
                fwd[gi] = FWD_REG;
                if (RegWriteM && (RdM != '0) && (RdM == rs_e[gi])) begin
                    fwd[gi] = FWD_M;
                end else if (RegWriteW && (RdW != '0) && (RdW == rs_e[gi])) begin
                    fwd[gi] = FWD_W;
                end
            end
        end
    endgenerate

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward controller with data-memory freeze and timeout watchdog.
// Optional HAZARD_PERF_EN adds StallCount/FlushCount performance counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Rs1D,
    input  logic [ADDR_W-1:0] Rs2D,
    input  logic [ADDR_W-1:0] Rs1E,
    input  logic [ADDR_W-1:0] Rs2E,
    input  logic [ADDR_W-1:0] RdE,
    input  logic [ADDR_W-1:0] RdM,
    input  logic [ADDR_W-1:0] RdW,
    input  logic [1:0]        ResultSrcE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MemErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    hazard_state_t     state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic              lw_stall;
    logic              eval_hazards;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e;
    logic [1:0]        fwd_a, fwd_b;

    assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != '0)
                   && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        eval_hazards = 1'b0;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;

        case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    wait_cnt_d = CNT_W'(1);
                    if (MEM_TIMEOUT <= 1) begin
                        state_d   = HALT;
                        mem_err_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else begin
                    eval_hazards = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    // Held E/D contents may still carry a hazard once the freeze lifts.
                    state_d      = RUN;
                    wait_cnt_d   = '0;
                    eval_hazards = 1'b1;
                end else begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    if (wait_cnt_q >= CNT_W'(MEM_TIMEOUT - 1)) begin
                        wait_cnt_d = CNT_W'(MEM_TIMEOUT);
                        state_d    = HALT;
                        mem_err_d  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            HALT: begin
                {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (eval_hazards) begin
            if (PCSrcE) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    forward_unit #(
        .ADDR_W(ADDR_W)
    ) u_forward_unit (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );

    // While in reset the pipeline registers are loaded with bubbles, never held.
    assign StallF    = rst_n & stall_f;
    assign StallD    = rst_n & stall_d;
    assign StallE    = rst_n & stall_e;
    assign StallM    = rst_n & stall_m;
    assign FlushD    = !rst_n | flush_d;
    assign FlushE    = !rst_n | flush_e;
    assign ForwardAE = rst_n ? fwd_a : FWD_REG;
    assign ForwardBE = rst_n ? fwd_b : FWD_REG;
    assign MemErr    = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    assign stall_count_d = stall_count_q + (StallF ? 32'd1 : 32'd0);
    assign flush_count_d = flush_count_q + (FlushE ? 32'd1 : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a default-timeout instance and a MEM_TIMEOUT=3 instance share stimulus.
module tb_hazard_unit;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]        ResultSrcE;
    logic              RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;

    logic       a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_err;
    logic [1:0] a_fa, a_fb;
    logic       b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_err;
    logic [1:0] b_fa, b_fb;
`ifdef HAZARD_PERF_EN
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_unit #(.ADDR_W(ADDR_W), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm),
        .FlushD(a_fd), .FlushE(a_fe), .ForwardAE(a_fa), .ForwardBE(a_fb),
        .MemErr(a_err)
`ifdef HAZARD_PERF_EN
        , .StallCount(a_stall_cnt), .FlushCount(a_flush_cnt)
`endif
    );

    hazard_unit #(.ADDR_W(ADDR_W), .MEM_TIMEOUT(3)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm),
        .FlushD(b_fd), .FlushE(b_fe), .ForwardAE(b_fa), .ForwardBE(b_fb),
        .MemErr(b_err)
`ifdef HAZARD_PERF_EN
        , .StallCount(b_stall_cnt), .FlushCount(b_flush_cnt)
`endif
    );

    // Observation word: {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE,MemErr}
    logic [10:0] obs_a, obs_b;
    assign obs_a = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fa, a_fb, a_err};
    assign obs_b = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fa, b_fb, b_err};

    typedef struct {
        string       tag;
        logic [10:0] exp;
        bit          is_to;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic logic [10:0] ex(input logic [3:0] st, input logic [1:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic err);
        return {st, fl, fa, fb, err};
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", tag, obs, exp);
        end else begin
            $display("ok   %s: %b", tag, obs);
        end
    endtask

    task automatic step(input string tag, input logic [10:0] exp_a,
                        input bit chk_b, input logic [10:0] exp_b);
        sb_t e;
        sb_q.push_back('{tag, exp_a, 1'b0});
        if (chk_b) sb_q.push_back('{{tag, "_to3"}, exp_b, 1'b1});
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, e.is_to ? obs_b : obs_a, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0; ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [10:0] IDLE, RSTV, LWV, BRV, FRZ, HLT;
        IDLE = ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0);
        RSTV = ex(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
        LWV  = ex(4'b1100, 2'b01, 2'b00, 2'b00, 1'b0);
        BRV  = ex(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0);
        FRZ  = ex(4'b1111, 2'b00, 2'b00, 2'b00, 1'b0);
        HLT  = ex(4'b1111, 2'b00, 2'b00, 2'b00, 1'b1);

        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        step("reset", RSTV, 1'b1, RSTV);
        RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3;
        step("reset_fwd_gated", RSTV, 1'b0, IDLE);
        clear_inputs();
        rst_n = 1'b1;
        step("release_idle", IDLE, 1'b1, IDLE);

        // Load-use: one bubble, then the load has moved on
        ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5;
        step("lw_rs2", LWV, 1'b0, IDLE);
        RdE = 5'd0;
        step("lw_rd0", IDLE, 1'b0, IDLE);
        RdE = 5'd7; Rs1D = 5'd7; Rs2D = 5'd0;
        step("lw_rs1", LWV, 1'b0, IDLE);
        ResultSrcE = 2'b00;
        step("alu_no_stall", IDLE, 1'b0, IDLE);
        ResultSrcE = 2'b10;
        step("pc4_no_stall", IDLE, 1'b0, IDLE);
        ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
        step("lw_x0", IDLE, 1'b0, IDLE);

        // Branch beats load-use
        RdE = 5'd5; Rs2D = 5'd5; PCSrcE = 1'b1;
        step("br_over_lw", BRV, 1'b0, IDLE);
        clear_inputs(); PCSrcE = 1'b1;
        step("branch", BRV, 1'b0, IDLE);
        clear_inputs();

        // Forwarding priority
        RegWriteM = 1'b1; RdM = 5'd3; RegWriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3;
        step("fwdA_M", ex(4'b0000, 2'b00, 2'b10, 2'b00, 1'b0), 1'b0, IDLE);
        RdM = 5'd0;
        step("fwdA_W", ex(4'b0000, 2'b00, 2'b01, 2'b00, 1'b0), 1'b0, IDLE);
        RdW = 5'd0; Rs1E = 5'd0;
        step("fwdA_reg", IDLE, 1'b0, IDLE);
        RegWriteM = 1'b0; RdM = 5'd4; RdW = 5'd4; Rs2E = 5'd4;
        step("fwdB_W_Mnowr", ex(4'b0000, 2'b00, 2'b00, 2'b01, 1'b0), 1'b0, IDLE);
        RegWriteM = 1'b1; Rs1E = 5'd4;
        step("fwdAB_M", ex(4'b0000, 2'b00, 2'b10, 2'b10, 1'b0), 1'b0, IDLE);
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        step("fwd_nowr", IDLE, 1'b0, IDLE);
        clear_inputs();

        // Memory freeze: four wait cycles then ready
        MemReqM = 1'b1; MemReadyM = 1'b0;
        step("memwait_1", FRZ, 1'b0, IDLE);
        step("memwait_2", FRZ, 1'b0, IDLE);
        ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5; PCSrcE = 1'b1;
        step("memwait_3_ign", FRZ, 1'b0, IDLE);
        PCSrcE = 1'b0;
        step("memwait_4_ign", FRZ, 1'b0, IDLE);
        MemReadyM = 1'b1;
        step("memready_reeval", LWV, 1'b0, IDLE);
        clear_inputs();
        step("after_ready", IDLE, 1'b0, IDLE);
        MemReqM = 1'b1; MemReadyM = 1'b1;
        step("req_ready_same", IDLE, 1'b0, IDLE);
        clear_inputs();

        // Watchdog: the MEM_TIMEOUT=3 instance halts after its third wait edge
        rst_n = 1'b0;
        step("reset2", RSTV, 1'b1, RSTV);
        rst_n = 1'b1;
        step("release2", IDLE, 1'b1, IDLE);
        MemReqM = 1'b1; MemReadyM = 1'b0;
        step("to_wait_1", FRZ, 1'b1, FRZ);
        step("to_wait_2", FRZ, 1'b1, FRZ);
        step("to_wait_3", FRZ, 1'b1, FRZ);
        step("to_halt", FRZ, 1'b1, HLT);
        MemReadyM = 1'b1; PCSrcE = 1'b1;
        step("halt_sticky", BRV, 1'b1, HLT);
        clear_inputs();
        rst_n = 1'b0;
        step("halt_reset", RSTV, 1'b1, RSTV);
        rst_n = 1'b1;
        step("halt_release", IDLE, 1'b1, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline controller for the five-stage RV32 core: sequences the F/D, D/E, E/M and M/W pipeline registers by generating stall, flush and forwarding controls. It resolves load-use and taken-branch/jump hazards and freezes the whole pipeline while the data memory has not acknowledged an access. A memory-wait watchdog latches a fatal error if the memory never responds.

## Interface
- ADDR_W, 5: register-address width for all Rs/Rd ports.
- MEM_TIMEOUT, 15: maximum consecutive wait cycles before MemErr; must be ≥1.
- clk  input  1  single pipeline clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- Rs1D, Rs2D  input  ADDR_W  source registers in Decode.
- Rs1E, Rs2E  input  ADDR_W  source registers in Execute.
- RdE, RdM, RdW  input  ADDR_W  destination registers in E/M/W.
- ResultSrcE  input  2  result select in Execute; load encoding is 2'b01.
- RegWriteM, RegWriteW  input  1  write-back enables in M/W.
- PCSrcE  input  1  taken branch or jump resolved in Execute.
- MemReqM  input  1  load or store active in Memory stage.
- MemReadyM  input  1  data memory acknowledge for the current access.
- StallF, StallD, StallE, StallM  output  1  hold the corresponding pipeline register.
- FlushD, FlushE  output  1  clear the F/D and D/E registers to a bubble.
- ForwardAE, ForwardBE  output  2  ALU operand select: 00 register file, 10 from M, 01 from W.
- MemErr  output  1  sticky memory-timeout error.

## Operation
- States: RUN, MEM_WAIT, HALT.
- RUN:
  - lwStall = ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - lwStall and !PCSrcE: StallF=StallD=1, FlushE=1.
  - PCSrcE: FlushD=FlushE=1, StallF=StallD=0; branch wins over a simultaneous lwStall.
  - MemReqM && !MemReadyM: StallF/D/E/M=1, flushes 0. Go to MEM_WAIT with wait_cnt=1.
- MEM_WAIT:
  - All four stalls 1; FlushD=FlushE=0; lwStall and PCSrcE are ignored.
  - MemReadyM=1: stalls drop in the same cycle; return to RUN with wait_cnt=0. Hazards are re-evaluated in that cycle from the held E/D contents.
  - MemReadyM=0: wait_cnt+1. When wait_cnt==MEM_TIMEOUT, go to HALT and set MemErr.
- HALT: all stalls 1, flushes 0, MemErr=1. Exit only by reset.
- Forwarding, per operand X in {1,2}, is combinational and independent of state:
  - 10 if RegWriteM && RdM!=0 && RdM==RsXE.
  - else 01 if RegWriteW && RdW!=0 && RdW==RsXE.
  - else 00. M has priority over W.
- wait_cnt width is $clog2(MEM_TIMEOUT+1) and never wraps; it saturates at MEM_TIMEOUT.
- x0 is never a hazard source (Rd==0 is excluded everywhere).

## Timing
- Reset (rst_n low, asynchronous):
  - state=RUN, wait_cnt=0, MemErr=0.
  - All stalls 0; FlushD=FlushE=1, so bubbles are loaded while in reset.
  - ForwardAE=ForwardBE=00.
- Stall and flush outputs are combinational from the current state and inputs, with zero added latency. State and MemErr update on the rising clk edge.
- Load-use costs exactly one bubble; a taken branch costs two flushed slots.
- The freeze begins in the same cycle MemReqM && !MemReadyM is first seen.
- MemReadyM arriving together with MemReqM in RUN causes no stall.
- Reset asserted mid-MEM_WAIT or in HALT returns to RUN immediately and clears MemErr.

## Configuration
- HAZARD_PERF_EN defined: adds two outputs.
  - StallCount, 32 bits: counts cycles with StallF=1.
  - FlushCount, 32 bits: counts cycles with FlushE=1 outside reset.
  - Both reset to 0 and wrap modulo 2^32.
- HAZARD_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- pipeline_pkg holds:
  - the ResultSrc encodings (RES_ALU=00, RES_LOAD=01, RES_PC4=10);
  - the forward-select constants FWD_REG, FWD_W, FWD_M;
  - the hazard_state_t enum {RUN, MEM_WAIT, HALT}.
- Sub-module forward_unit is purely combinational. It is instantiated once and produces ForwardAE and ForwardBE. The hazard_unit top holds the FSM, the watchdog counter and the perf counters.

## Test plan
- Reset release, all inputs 0 -> stalls 0, FlushD=FlushE=0, Forward 00, MemErr=0.
- ResultSrcE=01, RdE=5, Rs2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle. Then RdE=0 -> all 0.
- Same load-use with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- RegWriteM=1, RdM=3; RegWriteW=1, RdW=3; Rs1E=3 -> ForwardAE=10. Then RdM=0 -> ForwardAE=01. With RdW=0 and Rs1E=0 -> 00.
- MemReqM=1, MemReadyM=0 for 4 cycles, then 1 -> all stalls 1 for 4 cycles, 0 on the ready cycle, MemErr=0.
- MEM_TIMEOUT=3, MemReadyM held 0 -> MemErr=1 after the 3rd wait edge; stalls stay 1. rst_n pulse -> MemErr=0, state RUN.
